// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// State encoding is one-hot so IDLE decodes from a single flop.
package uart_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'b0001,
    S_LOAD     = 4'b0010,
    S_WAIT_ACK = 4'b0100,
    S_FRAME    = 4'b1000
  } state_t;

  localparam int ST_W = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // start bit + data bits at 16 ticks each, plus stop-bit ticks
  function automatic int frame_ticks(input int dbit, input int sb_tick);
    return (1 + dbit) * 16 + sb_tick;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin pick: first asserted req at or after ptr, wrapping.
// Purely combinational; the caller registers the result.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   idx,
  output logic            vld
);

  int j;

  always_comb begin
    win = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        win[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NREQ byte sources, round-robin,
// holding off the next grant until a full frame of s_ticks has elapsed.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter  int NREQ        = 4,
  parameter  int DBIT        = 8,
  parameter  int SB_TICK     = 16,
  parameter  int FRAME_TICKS = frame_ticks(DBIT, SB_TICK),
  parameter  int ACK_TO      = 64,
  localparam int IW          = clog2(NREQ),
  localparam int CW          = clog2(max2(FRAME_TICKS, ACK_TO)) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_tick,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DBIT-1:0] data,
  output logic [NREQ-1:0]      gnt,
  output logic                 tx_start,
  output logic [DBIT-1:0]      tx_din,
  input  logic                 tx_done_tick,
  output logic                 busy,
  output logic [IW-1:0]        cur_id,
  output logic                 ack_err
);

  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TO - 1);
  localparam logic [CW-1:0] FR_LAST  = CW'(FRAME_TICKS - 1);
  localparam logic [IW-1:0] LAST_ID  = IW'(NREQ - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   rr_ptr;
  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            win_vld;
  logic [DBIT-1:0] src [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_src
    assign src[i] = data[i*DBIT +: DBIT];
  end

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .win (win_oh),
    .idx (win_idx),
    .vld (win_vld)
  );

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gnt      <= '0;
      tx_start <= 1'b0;
      tx_din   <= '0;
      cur_id   <= '0;
      ack_err  <= 1'b0;
      rr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      gnt <= '0;
      unique case (state)
        S_IDLE: begin
          if (win_vld) begin
            tx_din <= src[win_idx];
            cur_id <= win_idx;
            gnt    <= win_oh;
            rr_ptr <= (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          tx_start <= 1'b1;
          cnt      <= '0;
          state    <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // an ack arriving on the expiry tick still counts as success
          if (tx_done_tick) begin
            tx_start <= 1'b0;
            cnt      <= '0;
            state    <= S_FRAME;
          end else if (s_tick) begin
            if (cnt >= ACK_LAST) begin
              ack_err  <= 1'b1;
              tx_start <= 1'b0;
              cnt      <= '0;
              state    <= S_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_FRAME: begin
          if (s_tick) begin
            if (cnt >= FR_LAST) begin
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          tx_start <= 1'b0;
          cnt      <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: scoreboard of expected grants
// plus a tick generator and a simple transmitter ack model.
module tb_uart_tx_sched;

  localparam int NREQ = 4;
  localparam int DBIT = 8;
  localparam int FT   = 160;
  localparam int ATO  = 64;

  logic            clk;
  logic            rst_n;
  logic            s_tick;
  logic [3:0]      req;
  logic [31:0]     data;
  logic [3:0]      gnt;
  logic            tx_start;
  logic [7:0]      tx_din;
  logic            tx_done_tick;
  logic            busy;
  logic [1:0]      cur_id;
  logic            ack_err;

  uart_tx_sched #(
    .NREQ (NREQ),
    .DBIT (DBIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_tick       (s_tick),
    .req          (req),
    .data         (data),
    .gnt          (gnt),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .cur_id       (cur_id),
    .ack_err      (ack_err)
  );

  typedef struct {
    int         id;
    logic [7:0] dat;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   tick_n = 0;
  int   last_t = 0;
  bit   have_last = 0;
  bit   gap_en = 0;
  bit   ack_en = 1;
  int   ack_after = 5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // s_tick every 4th clock; transmitter acks on its ack_after-th tick
  initial begin
    int div;
    int st_n;
    bit dsent;
    div = 0; st_n = 0; dsent = 0;
    s_tick = 1'b0;
    tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      div = (div == 3) ? 0 : div + 1;
      s_tick = (div == 0);
      if (s_tick) tick_n++;
      tx_done_tick = 1'b0;
      if (tx_start && rst_n) begin
        if (s_tick) st_n++;
        if (ack_en && !dsent && st_n == ack_after) begin
          tx_done_tick = 1'b1;
          dsent = 1;
        end
      end else begin
        st_n = 0;
        dsent = 0;
      end
    end
  end

  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (rst_n && |gnt) begin
      if (q.size() == 0) begin
        check("gnt_unexpected", 32'(gnt), 32'd0);
      end else begin
        e = q.pop_front();
        check("gnt_id", 32'(cur_id), 32'(e.id));
        check("gnt_onehot", 32'(gnt), 32'd1 << e.id);
        check("tx_din", 32'(tx_din), 32'(e.dat));
        if (gap_en && have_last)
          check("gap_ge_frame", 32'(tick_n - last_t >= FT), 32'd1);
        last_t = tick_n;
        have_last = 1;
      end
    end
  end

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.dat = d;
    q.push_back(e);
  endtask

  task automatic serve(input int n, input bit hold);
    int got;
    int b;
    got = 0;
    b = 0;
    while (got < n && b < 5000) begin
      sample();
      b++;
      if (|gnt) begin
        got++;
        if (!hold) req = req & ~gnt;
      end
    end
    if (got < n) check("serve_timeout", 32'(got), 32'(n));
  endtask

  task automatic wait_fall(output int t0);
    int  b;
    bit  seen;
    b = 0;
    seen = 0;
    t0 = tick_n;
    while (b < 2000) begin
      sample();
      b++;
      if (tx_start) seen = 1;
      else if (seen) break;
    end
    t0 = tick_n;
    if (b >= 2000) check("fall_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int t0, output int dt);
    int b;
    b = 0;
    dt = 0;
    while (b < 3000) begin
      sample();
      b++;
      if (!busy) break;
    end
    dt = tick_n - t0;
    if (b >= 3000) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_tx_din"}, 32'(tx_din), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cur_id"}, 32'(cur_id), 32'd0);
    check({tag, "_ack_err"}, 32'(ack_err), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) sample();
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int dt;
    rst_n = 1'b0;
    req = '0;
    data = '0;
    repeat (3) sample();
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // single source, normal ack
    data[23:16] = 8'hA5;
    push(2, 8'hA5);
    req = 4'b0100;
    serve(1, 0);
    sample();
    check("t1_tx_start_held", 32'(tx_start), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    wait_fall(t0);
    check("t1_frame_busy", 32'(busy), 32'd1);
    wait_idle(t0, dt);
    check("t1_frame_ticks", 32'(dt), 32'(FT));

    // all sources held high from pointer 0
    do_reset();
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    push(0, 8'h10); push(1, 8'h11); push(2, 8'h12);
    push(3, 8'h13); push(0, 8'h10);
    have_last = 0;
    gap_en = 1;
    req = 4'b1111;
    serve(5, 1);
    req = '0;
    wait_idle(tick_n, dt);
    gap_en = 0;

    // pointer wrap: after 3 wins, 1 goes before 3
    data[31:24] = 8'h33;
    push(3, 8'h33);
    req = 4'b1000;
    serve(1, 0);
    wait_idle(tick_n, dt);
    data[15:8] = 8'h21;
    data[31:24] = 8'h23;
    push(1, 8'h21); push(3, 8'h23);
    req = 4'b1010;
    serve(2, 0);
    wait_idle(tick_n, dt);

    // ack timeout, then normal service continues
    ack_en = 0;
    data[7:0] = 8'h3C;
    push(0, 8'h3C);
    req = 4'b0001;
    serve(1, 0);
    sample();
    t0 = tick_n;
    check("t4_tx_start", 32'(tx_start), 32'd1);
    wait_idle(t0, dt);
    check("t4_ack_to_ticks", 32'(dt), 32'(ATO));
    check("t4_ack_err", 32'(ack_err), 32'd1);
    check("t4_tx_start_drop", 32'(tx_start), 32'd0);
    ack_en = 1;
    data[15:8] = 8'h5A;
    push(1, 8'h5A);
    req = 4'b0010;
    serve(1, 0);
    wait_fall(t0);
    wait_idle(t0, dt);
    check("t4_next_frame_ticks", 32'(dt), 32'(FT));
    check("t4_ack_err_sticky", 32'(ack_err), 32'd1);

    // async reset in the middle of a frame
    data[23:16] = 8'h77;
    push(2, 8'h77);
    req = 4'b0100;
    serve(1, 0);
    wait_fall(t0);
    repeat (20) sample();
    check("t5_in_frame", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_reset("t5_async");
    @(negedge clk);
    rst_n = 1'b1;
    data[7:0] = 8'h50;
    data[31:24] = 8'h53;
    push(0, 8'h50); push(3, 8'h53);
    req = 4'b1001;
    serve(2, 0);
    wait_idle(tick_n, dt);

    // ack on the same tick as the timeout expiry
    ack_after = ATO;
    data[31:24] = 8'hC3;
    push(3, 8'hC3);
    req = 4'b1000;
    serve(1, 0);
    wait_fall(t0);
    check("t6_frame_entered", 32'(busy), 32'd1);
    check("t6_no_ack_err", 32'(ack_err), 32'd0);
    wait_idle(t0, dt);
    check("t6_frame_ticks", 32'(dt), 32'(FT));
    check("t6_ack_err_final", 32'(ack_err), 32'd0);
    ack_after = 5;

    repeat (4) sample();
    check("sb_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
